// File: rtl/day_9_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | day_9_arb_pkg : shared sizes and FSM encoding for the 16-way       |
// | round-robin arbiter.                              Rev 1.0          |
// +--------------------------------------------------------------------+
package day_9_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/day_9_round_robin_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | day_9_round_robin_arbiter_if : request/grant bundle of the arbiter |
// |                                                   Rev 1.0          |
// +--------------------------------------------------------------------+
interface day_9_round_robin_arbiter_if;
  import day_9_arb_pkg::*;

  logic [NUM_REQ-1:0] req_i;
  logic               gnt_valid_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic [NUM_REQ-1:0] gnt_o;
  logic               timeout_o;

  modport master (
    output req_i,
    input  gnt_valid_o,
    input  gnt_idx_o,
    input  gnt_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    output gnt_valid_o,
    output gnt_idx_o,
    output gnt_o,
    output timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/day_8_binary_to_onehot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | day_8_binary_to_onehot : binary index to one-hot decoder.          |
// |                                                   Rev 1.0          |
// +--------------------------------------------------------------------+
module day_8_binary_to_onehot #(
  parameter int BIN_W = 4,
  parameter int OUT_W = 16
) (
  input  logic [BIN_W-1:0] bin_i,
  output logic [OUT_W-1:0] one_hot_o
);

  assign one_hot_o = OUT_W'(1) << bin_i;

endmodule
`default_nettype wire

// File: rtl/day_9_round_robin_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | day_9_round_robin_arbiter : 16-way round-robin arbiter with a      |
// | registered binary winner and per-win hold timeout.  Rev 1.0        |
// +--------------------------------------------------------------------+
module day_9_round_robin_arbiter
  import day_9_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  day_9_round_robin_arbiter_if.slave arb
);

  // With no timeout the counter simply saturates at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;
  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] onehot;
  logic               req_held;
  logic               hold_expired;

  // First set bit searching base, base+1, ..., wrapping through 15 to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] win;
    win = base;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'(k) + base;
      if (req[j]) win = j;
    end
    return win;
  endfunction

  assign req_held     = arb.req_i[gnt_idx];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb.req_i) begin
            gnt_idx   <= rr_pick(arb.req_i, ptr);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req_held || hold_expired) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
            timeout   <= req_held;
            state     <= IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  day_8_binary_to_onehot #(
    .BIN_W (IDX_W),
    .OUT_W (NUM_REQ)
  ) u_dec (
    .bin_i     (gnt_idx),
    .one_hot_o (onehot)
  );

  assign arb.gnt_valid_o = gnt_valid;
  assign arb.gnt_idx_o   = gnt_idx;
  assign arb.gnt_o       = gnt_valid ? onehot : '0;
  assign arb.timeout_o   = timeout;

endmodule
`default_nettype wire

// File: tb/tb_day_9_round_robin_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_day_9_round_robin_arbiter : directed vector bench, MAX_HOLD=4.  |
// |                                                   Rev 1.0          |
// +--------------------------------------------------------------------+
module tb_day_9_round_robin_arbiter;

  typedef struct {
    logic [15:0] req;
    logic        valid;
    logic [3:0]  idx;
    logic        to;
  } vec_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  vec_t tbl[$];

  day_9_round_robin_arbiter_if bus ();

  day_9_round_robin_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [3:0] idx,
                            input logic to);
    logic [15:0] g;
    g = v ? (16'h0001 << idx) : 16'h0000;
    chk({nm, " valid"},   32'(bus.gnt_valid_o), 32'(v));
    chk({nm, " gnt"},     32'(bus.gnt_o),       32'(g));
    chk({nm, " timeout"}, 32'(bus.timeout_o),   32'(to));
    if (v) chk({nm, " idx"}, 32'(bus.gnt_idx_o), 32'(idx));
  endtask

  // Four granted cycles followed by the turnaround cycle carrying the timeout.
  task automatic run_hold(input string nm, input logic [3:0] idx);
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out(nm, 1'b1, idx, 1'b0);
    end
    step();
    expect_out({nm, " turnaround"}, 1'b0, idx, 1'b1);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    tbl.push_back('{16'h0008, 1'b1, 4'd3, 1'b0});
    tbl.push_back('{16'h0008, 1'b1, 4'd3, 1'b0});
    tbl.push_back('{16'h0008, 1'b1, 4'd3, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{16'h0011, 1'b1, 4'd4, 1'b0});
    tbl.push_back('{16'h0011, 1'b1, 4'd4, 1'b0});
    tbl.push_back('{16'h0001, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{16'h0001, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{16'h0001, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{16'h0003, 1'b1, 4'd1, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 4'd0, 1'b0});
    tbl.push_back('{16'h0003, 1'b1, 4'd0, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 4'd0, 1'b0});

    // Reset with every requester active
    reset_n    = 1'b0;
    bus.req_i  = 16'hFFFF;
    step();
    step();
    expect_out("reset", 1'b0, 4'd0, 1'b0);
    chk("reset idx", 32'(bus.gnt_idx_o), 32'd0);
    reset_n = 1'b1;
    step();
    expect_out("first grant", 1'b1, 4'd0, 1'b0);
    bus.req_i = 16'h0000;
    step();
    expect_out("first release", 1'b0, 4'd0, 1'b0);

    // Table: single requester, pointer at 4, wrap of the search
    foreach (tbl[i]) begin
      bus.req_i = tbl[i].req;
      step();
      expect_out($sformatf("vec%0d", i), tbl[i].valid, tbl[i].idx, tbl[i].to);
    end

    // Full load from a clean pointer: 0..15 then 0 again, each timed out
    #3 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    bus.req_i = 16'hFFFF;
    for (int g = 0; g < 17; g++) run_hold($sformatf("sweep%0d", g), 4'(g % 16));

    // Sole requester 15 wins again after its own timeout
    bus.req_i = 16'h8000;
    run_hold("sole15", 4'd15);
    step();
    expect_out("sole15 regrant", 1'b1, 4'd15, 1'b0);
    bus.req_i = 16'h0000;
    step();
    expect_out("sole15 release", 1'b0, 4'd0, 1'b0);

    // Timed-out requester loses to the other active one
    bus.req_i = 16'h0005;
    run_hold("pair0", 4'd0);
    run_hold("pair2", 4'd2);
    step();
    expect_out("pair wrap", 1'b1, 4'd0, 1'b0);
    bus.req_i = 16'h0000;
    step();
    expect_out("pair release", 1'b0, 4'd0, 1'b0);

    // Asynchronous reset in the middle of grant 7
    bus.req_i = 16'h0080;
    step();
    expect_out("grant7", 1'b1, 4'd7, 1'b0);
    step();
    expect_out("grant7 hold", 1'b1, 4'd7, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    expect_out("async reset", 1'b0, 4'd0, 1'b0);
    #2 reset_n = 1'b1;
    bus.req_i = 16'h0090;
    step();
    expect_out("post reset", 1'b1, 4'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
